// File: rtl/wb_grf.sv
// rtl/wb_grf.sv - W-stage write-back decode and 32x32 register file with write-through read bypass
// Optional GRF_TRACE_EN: prints one line per committed register write.
module wb_grf #(
  parameter logic [31:0] JAL_LINK_OFFSET = 32'd8,
  parameter logic [4:0]  LINK_REG        = 5'd31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_alu_out,
  input  logic [31:0] in_dm_out,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] out_rs_data,
  output logic [31:0] out_rt_data,
  output logic        out_we,
  output logic [4:0]  out_waddr,
  output logic [31:0] out_wdata
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        dec_write;
  logic [4:0]  dec_addr;
  logic [31:0] dec_data;
  logic [31:0] regs [32];
  logic        unused_bits;

  assign op          = in_instr[31:26];
  assign rt          = in_instr[20:16];
  assign rd          = in_instr[15:11];
  assign funct       = in_instr[5:0];
  assign unused_bits = ^{in_instr[25:21], in_instr[10:6]};

  always_comb begin
    dec_write = 1'b0;
    dec_addr  = 5'd0;
    dec_data  = 32'd0;
    case (op)
      6'b000000: begin
        if (funct == 6'b100001 || funct == 6'b100011) begin
          dec_write = 1'b1;
          dec_addr  = rd;
          dec_data  = in_alu_out;
        end
      end
      6'b001101, 6'b001111: begin
        dec_write = 1'b1;
        dec_addr  = rt;
        dec_data  = in_alu_out;
      end
      6'b100011: begin
        dec_write = 1'b1;
        dec_addr  = rt;
        dec_data  = in_dm_out;
      end
      6'b000011: begin
        dec_write = 1'b1;
        dec_addr  = LINK_REG;
        dec_data  = in_pc + JAL_LINK_OFFSET;
      end
      default: begin
        dec_write = 1'b0;
      end
    endcase
  end

  // $0 writes and anything during reset are squashed here, so the array and the bypass both see them as no-ops
  assign out_we    = dec_write && (dec_addr != 5'd0) && !reset;
  assign out_waddr = out_we ? dec_addr : 5'd0;
  assign out_wdata = out_we ? dec_data : 32'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (out_we) begin
      regs[out_waddr] <= out_wdata;
    end
  end

  assign out_rs_data = (rs_addr == 5'd0 || reset) ? 32'd0 :
                       (out_we && rs_addr == out_waddr) ? out_wdata : regs[rs_addr];
  assign out_rt_data = (rt_addr == 5'd0 || reset) ? 32'd0 :
                       (out_we && rt_addr == out_waddr) ? out_wdata : regs[rt_addr];

`ifdef GRF_TRACE_EN
  always @(posedge clk) begin
    if (out_we) begin
      $display("%d@%h: $%d <= %h", $time, in_pc, out_waddr, out_wdata);
    end
  end
`endif

endmodule

// File: tb/tb_wb_grf.sv
// tb/tb_wb_grf.sv - self-checking bench for wb_grf: directed vector table, async reset sequence, random vs. model
module tb_wb_grf;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_pc, in_instr, in_alu_out, in_dm_out;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] out_rs_data, out_rt_data;
  logic        out_we;
  logic [4:0]  out_waddr;
  logic [31:0] out_wdata;

  wb_grf dut (
    .clk(clk), .reset(reset),
    .in_pc(in_pc), .in_instr(in_instr), .in_alu_out(in_alu_out), .in_dm_out(in_dm_out),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .out_rs_data(out_rs_data), .out_rt_data(out_rt_data),
    .out_we(out_we), .out_waddr(out_waddr), .out_wdata(out_wdata)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  logic [31:0] model [32];

  typedef struct {
    logic [31:0] instr, pc, alu, dm;
    logic [4:0]  rs, rt;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata, rsd, rtd;
  } vec_t;
  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] dm, input logic [4:0] rs, input logic [4:0] rt);
    in_instr = instr; in_pc = pc; in_alu_out = alu; in_dm_out = dm;
    rs_addr = rs; rt_addr = rt;
  endtask

  task automatic check_all(input string tag, input logic we, input logic [4:0] waddr,
                           input logic [31:0] wdata, input logic [31:0] rsd, input logic [31:0] rtd);
    check({tag, ".we"}, {31'd0, out_we}, {31'd0, we});
    check({tag, ".waddr"}, {27'd0, out_waddr}, {27'd0, waddr});
    check({tag, ".wdata"}, out_wdata, wdata);
    check({tag, ".rs"}, out_rs_data, rsd);
    check({tag, ".rt"}, out_rt_data, rtd);
  endtask

  initial begin
    vecs[0]  = '{32'h3405_1234, 32'h0, 32'h1234, 32'h0, 5'd5, 5'd0, 1'b1, 5'd5, 32'h1234, 32'h1234, 32'h0};
    vecs[1]  = '{32'h0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd5, 1'b0, 5'd0, 32'h0, 32'h1234, 32'h1234};
    vecs[2]  = '{32'h8C08_0000, 32'h0, 32'h10, 32'hDEAD_BEEF, 5'd8, 5'd5, 1'b1, 5'd8, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1234};
    vecs[3]  = '{32'h0108_4821, 32'h0, 32'h5, 32'h77, 5'd9, 5'd8, 1'b1, 5'd9, 32'h5, 32'h5, 32'hDEAD_BEEF};
    vecs[4]  = '{32'h0C00_0C10, 32'h3008, 32'h0, 32'h0, 5'd31, 5'd9, 1'b1, 5'd31, 32'h3010, 32'h3010, 32'h5};
    vecs[5]  = '{32'h0108_0021, 32'h0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd9, 1'b0, 5'd0, 32'h0, 32'h0, 32'h5};
    vecs[6]  = '{32'hAC08_0004, 32'h0, 32'h1234, 32'h55, 5'd8, 5'd31, 1'b0, 5'd0, 32'h0, 32'hDEAD_BEEF, 32'h3010};
    vecs[7]  = '{32'h1108_0001, 32'h0, 32'h9, 32'h9, 5'd9, 5'd5, 1'b0, 5'd0, 32'h0, 32'h5, 32'h1234};
    vecs[8]  = '{32'h03E0_0008, 32'h0, 32'h31, 32'h0, 5'd31, 5'd0, 1'b0, 5'd0, 32'h0, 32'h3010, 32'h0};
    vecs[9]  = '{32'h0C00_0001, 32'hFFFF_FFFC, 32'h0, 32'h0, 5'd31, 5'd31, 1'b1, 5'd31, 32'h4, 32'h4, 32'h4};
    vecs[10] = '{32'h0128_5023, 32'h0, 32'hABCD, 32'h0, 5'd10, 5'd31, 1'b1, 5'd10, 32'hABCD, 32'hABCD, 32'h4};
    vecs[11] = '{32'h3C03_BEEF, 32'h0, 32'hBEEF_0000, 32'h0, 5'd3, 5'd10, 1'b1, 5'd3, 32'hBEEF_0000, 32'hBEEF_0000, 32'hABCD};

    reset = 1'b1;
    drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd31);
    #3 check_all("reset", 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    #3 check_all("released", 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].instr, vecs[i].pc, vecs[i].alu, vecs[i].dm, vecs[i].rs, vecs[i].rt);
      #3 check_all($sformatf("vec%0d", i), vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].rsd, vecs[i].rtd);
      @(posedge clk); #1;
    end

    drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd3);
    #1 check("pre_rst.rs", out_rs_data, 32'h1234);
    check("pre_rst.rt", out_rt_data, 32'hBEEF_0000);
    #1 reset = 1'b1;
    #1 check("async_rst.rs", out_rs_data, 32'h0);
    check("async_rst.rt", out_rt_data, 32'h0);
    drive(32'h3407_0077, 32'h0, 32'h77, 32'h0, 5'd7, 5'd5);
    #1 check_all("write_in_rst", 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1 in_instr = 32'h0;
    #1 reset = 1'b0;
    #1 check("dropped.rs", out_rs_data, 32'h0);
    check("cleared.rt", out_rt_data, 32'h0);
    drive(32'h3405_0042, 32'h0, 32'h42, 32'h0, 5'd5, 5'd7);
    #1 check_all("post_rst_wr", 1'b1, 5'd5, 32'h42, 32'h42, 32'h0);
    @(posedge clk); #1 in_instr = 32'h0;
    #1 check("post_rst_commit", out_rs_data, 32'h42);
    @(posedge clk); #1;

    for (int r = 0; r < 32; r++) model[r] = 32'h0;
    model[5] = 32'h42;

    for (int i = 0; i < 400; i++) begin
      int          kind;
      logic [4:0]  fs, ft, fd;
      logic [15:0] imm;
      logic [31:0] instr, pc, alu, dm, data, ers, ert;
      logic        w;
      logic [4:0]  dest;
      kind = int'($urandom_range(0, 11));
      fs = 5'($urandom_range(0, 7)); ft = 5'($urandom_range(0, 7)); fd = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) fd = 5'($urandom);
      imm = 16'($urandom); pc = $urandom; alu = $urandom; dm = $urandom;
      w = 1'b0; dest = 5'd0; data = 32'h0;
      case (kind)
        0:  begin instr = {6'h00, fs, ft, fd, 5'd0, 6'h21}; w = 1'b1; dest = fd; data = alu; end
        1:  begin instr = {6'h00, fs, ft, fd, 5'd0, 6'h23}; w = 1'b1; dest = fd; data = alu; end
        2:  instr = {6'h00, fs, 15'd0, 6'h08};
        3:  begin instr = {6'h0D, fs, ft, imm}; w = 1'b1; dest = ft; data = alu; end
        4:  begin instr = {6'h0F, 5'd0, ft, imm}; w = 1'b1; dest = ft; data = alu; end
        5:  begin instr = {6'h23, fs, ft, imm}; w = 1'b1; dest = ft; data = dm; end
        6:  begin instr = {6'h03, 26'($urandom)}; w = 1'b1; dest = 5'd31; data = pc + 32'd8; end
        7:  instr = {6'h2B, fs, ft, imm};
        8:  instr = {6'h04, fs, ft, imm};
        9:  instr = 32'h0;
        10: instr = {6'h00, fs, ft, fd, 5'd0, 6'h20};
        default: instr = {6'h02, 26'($urandom)};
      endcase
      if (dest == 5'd0) w = 1'b0;
      if (!w) begin dest = 5'd0; data = 32'h0; end
      drive(instr, pc, alu, dm, ($urandom_range(0, 2) == 0) ? dest : 5'($urandom_range(0, 7)),
            ($urandom_range(0, 2) == 0) ? dest : 5'($urandom));
      ers = (rs_addr == 5'd0) ? 32'h0 : (w && rs_addr == dest) ? data : model[rs_addr];
      ert = (rt_addr == 5'd0) ? 32'h0 : (w && rt_addr == dest) ? data : model[rt_addr];
      #3 check_all($sformatf("rnd%0d.k%0d", i, kind), w, dest, data, ers, ert);
      @(posedge clk); #1;
      if (w) model[dest] = data;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
